// File: rtl/rpsc_on_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rpsc_on_sequencer: FAN -> CA -> G1 -> ANODE power sequencer with ON       |
// | timeouts, inter-stage dwell, reverse shutdown and trapped faults.         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rpsc_on_sequencer #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int DWELL_CYC   = 100,
  parameter int CNT_W       = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  input  logic [3:0] perm_i,
  input  logic [3:0] on_fb_i,
  output logic [3:0] cmd_o,
  output logic       busy_o,
  output logic       all_on_o,
  output logic       fault_o,
  output logic [1:0] fault_stage_o,
  output logic [1:0] fault_code_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_DWELL    = 3'd2,
    ST_RUN      = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [1:0] CODE_TIMEOUT   = 2'd0;
  localparam logic [1:0] CODE_PERM      = 2'd1;
  localparam logic [1:0] CODE_FB        = 2'd2;

  state_t           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             busy_q, busy_d;
  logic             all_on_q, all_on_d;
  logic             fault_q, fault_d;
  logic [1:0]       fstage_q, fstage_d;
  logic [1:0]       fcode_q, fcode_d;

  logic [3:0] conf;
  logic [3:0] perm_bad;
  logic [3:0] fb_bad;
  logic       sup_fault;
  logic [1:0] sup_stage;
  logic [1:0] sup_code;
  logic [1:0] k_nx;
  logic       dwell_done;
  logic       trap;
  logic [1:0] trap_stage;
  logic [1:0] trap_code;
  logic       go_down;
  logic       step_clr;

  assign k_nx       = k_q + 2'd1;
  assign dwell_done = (cnt_q == DW_LAST);

  // Stages whose ON feedback is already confirmed and must stay asserted.
  always_comb begin
    conf = '0;
    for (int j = 0; j < 4; j++) begin
      case (state_q)
        ST_RAMP:          conf[j] = (2'(j) < k_q);
        ST_DWELL, ST_RUN: conf[j] = (2'(j) <= k_q);
        ST_SHUTDOWN:      conf[j] = cmd_q[j];
        default:          conf[j] = 1'b0;
      endcase
    end
  end

  assign perm_bad = cmd_q & ~perm_i;
  assign fb_bad   = conf & ~on_fb_i;

  always_comb begin
    sup_fault = |(perm_bad | fb_bad);
    sup_stage = '0;
    sup_code  = CODE_TIMEOUT;
    for (int j = 3; j >= 0; j--) begin
      if (perm_bad[j] || fb_bad[j]) begin
        sup_stage = 2'(j);
        sup_code  = perm_bad[j] ? CODE_PERM : CODE_FB;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cmd_d      = cmd_q;
    fault_d    = fault_q;
    fstage_d   = fstage_q;
    fcode_d    = fcode_q;
    trap       = 1'b0;
    trap_stage = '0;
    trap_code  = CODE_TIMEOUT;
    go_down    = 1'b0;
    step_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i && perm_i[0]) begin
          state_d = ST_RAMP;
          k_d     = 2'd0;
          cmd_d   = 4'b0001;
        end
      end
      ST_RAMP: begin
        if (sup_fault) begin
          trap = 1'b1; trap_stage = sup_stage; trap_code = sup_code;
        end else if (!on_fb_i[k_q] && cnt_q == TO_LAST) begin
          trap = 1'b1; trap_stage = k_q; trap_code = CODE_TIMEOUT;
        end else if (stop_i) begin
          go_down = 1'b1;
        end else if (on_fb_i[k_q]) begin
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (sup_fault) begin
          trap = 1'b1; trap_stage = sup_stage; trap_code = sup_code;
        end else if (dwell_done && k_q != 2'd3 && !perm_i[k_nx]) begin
          trap = 1'b1; trap_stage = k_nx; trap_code = CODE_PERM;
        end else if (stop_i) begin
          go_down = 1'b1;
        end else if (dwell_done) begin
          if (k_q == 2'd3) begin
            state_d = ST_RUN;
          end else begin
            state_d     = ST_RAMP;
            k_d         = k_nx;
            cmd_d[k_nx] = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (sup_fault) begin
          trap = 1'b1; trap_stage = sup_stage; trap_code = sup_code;
        end else if (stop_i) begin
          go_down = 1'b1;
        end
      end
      ST_SHUTDOWN: begin
        if (sup_fault) begin
          trap = 1'b1; trap_stage = sup_stage; trap_code = sup_code;
        end else if (dwell_done) begin
          cmd_d[k_q] = 1'b0;
          step_clr   = 1'b1;
          if (k_q == 2'd0) state_d = ST_IDLE;
          else             k_d     = k_q - 2'd1;
        end
      end
      ST_FAULT: begin
        if (clear_i) begin
          state_d  = ST_IDLE;
          fault_d  = 1'b0;
          fstage_d = '0;
          fcode_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // k always names the highest commanded stage, so that is the bit to drop.
    if (go_down) begin
      cmd_d[k_q] = 1'b0;
      if (k_q == 2'd0) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_SHUTDOWN;
        k_d     = k_q - 2'd1;
      end
    end

    if (trap) begin
      state_d  = ST_FAULT;
      k_d      = '0;
      cmd_d    = '0;
      fault_d  = 1'b1;
      fstage_d = trap_stage;
      fcode_d  = trap_code;
    end

    busy_d   = (state_d == ST_RAMP) || (state_d == ST_DWELL) || (state_d == ST_SHUTDOWN);
    all_on_d = (state_d == ST_RUN);

    if (state_d != state_q || step_clr)
      cnt_d = '0;
    else if (busy_d)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    else
      cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      busy_q   <= 1'b0;
      all_on_q <= 1'b0;
      fault_q  <= 1'b0;
      fstage_q <= '0;
      fcode_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      all_on_q <= all_on_d;
      fault_q  <= fault_d;
      fstage_q <= fstage_d;
      fcode_q  <= fcode_d;
    end
  end

  assign cmd_o         = cmd_q;
  assign busy_o        = busy_q;
  assign all_on_o      = all_on_q;
  assign fault_o       = fault_q;
  assign fault_stage_o = fstage_q;
  assign fault_code_o  = fcode_q;

endmodule
`default_nettype wire
